pipeline_controller: RTL
========================

// Module: pipeline_controller
// PURPOSE
//  Central sequencer for the 5-stage RISC-V pipeline. Merges the stage-2 hazard stall, stage-2 taken
//  branch, stage-4 memory wait and WB halt into per-stage enables, flushes and bubbles.
//  Runs a small FSM for multi-cycle memory waits (with timeout), halt and error.
//  Keeps saturating stall and flush performance counters. Sits beside the stages and drives their pipe-register enables.
// PARAMETERS
//  MEM_TIMEOUT  255  max cycles in MEM_WAIT before ERROR (1..2^TO_W-1)
//  TO_W         8    width of the memory-wait counter
//  CNT_W        32   width of the performance counters
// PORTS
//  i_clk         in   1      clock, rising edge
//  i_rst         in   1      asynchronous, active-high reset
//  i_stall_req   in   1      load-use/data hazard stall from stage 2 (combinational)
//  i_b_taken     in   1      taken branch/jump resolved in stage 2
//  i_mem_req     in   1      stage 4 holds a load/store this cycle
//  i_mem_ready   in   1      data memory completes the access this cycle
//  i_halt        in   1      ECALL/EBREAK retiring in WB
//  i_resume      in   1      leave HALT
//  pc_en         out  1      PC register update enable
//  if_id_en      out  1      IF/ID pipe register enable
//  if_id_flush   out  1      IF/ID load NOP (wins over if_id_en)
//  id_ex_en      out  1      ID/EX pipe register enable
//  id_ex_bubble  out  1      ID/EX load bubble (opcode 0, rd_num 0)
//  ex_mem_en     out  1      EX/MEM pipe register enable
//  mem_wb_en     out  1      MEM/WB pipe register enable
//  state         out  2      RUN=0, MEM_WAIT=1, HALT=2, ERROR=3
//  err           out  1      memory timeout, sticky until reset
//  stall_cnt     out  CNT_W  cycles with pc_en=0 outside HALT/ERROR, saturating
//  flush_cnt     out  CNT_W  cycles with if_id_flush=1, saturating
// BEHAVIOUR
//  Reset (async): state=RUN, wait counter=0, err=0, both counters=0.
//   During reset all enables=0; flush=0; bubble=0.
//  Control outputs are combinational from state and inputs. state, err, counters are registered.
//  RUN, evaluated in priority order:
//   1. mem_hit = i_mem_req & ~i_mem_ready: freeze.
//      All enables=0; flush=0; bubble=0. Next state=MEM_WAIT; wait counter<=1.
//   2. i_stall_req: pc_en=0, if_id_en=0, id_ex_bubble=1, ex_mem_en=mem_wb_en=1.
//      i_b_taken is ignored while stalled, because stage 2 gates it.
//   3. i_b_taken: all enables=1, if_id_flush=1 for exactly this cycle.
//   4. Otherwise all enables=1.
//   i_halt in RUN overrides rules 1-4 at the next edge: next state=HALT.
//    In the current cycle, mem_wb_en=0 so the halting instruction stays in WB.
//    All other outputs follow rules 1-4.
//  MEM_WAIT: all enables=0, no flush, no bubble.
//   i_mem_ready=1: that cycle all enables=1, with rules 2/3 applied as in RUN. Next state=RUN.
//   Otherwise the wait counter increments. When wait counter==MEM_TIMEOUT and ready=0: next state=ERROR, err<=1.
//   Ready on the exact timeout cycle wins, and the state returns to RUN.
//  HALT: all enables=0. i_resume=1 -> next state=RUN. i_halt is ignored while in HALT.
//  ERROR: all enables=0; only i_rst leaves this state.
//  A branch during a freeze is not lost. Stage 2 is held, so i_b_taken is re-presented and acted on in the first advancing cycle.
//  Counters increment by 1 per qualifying cycle and hold at all-ones. The wait counter clears on every entry to RUN.
//  Reset mid-MEM_WAIT or mid-HALT returns to RUN next cycle, with counters cleared.
// TESTING
//  T1 i_b_taken=1 one cycle in RUN -> if_id_flush=1, pc_en=1 that cycle only; flush_cnt=1.
//  T2 i_stall_req=1 for 2 cycles -> pc_en=if_id_en=0, id_ex_bubble=1, ex_mem_en=1 both cycles; stall_cnt=2.
//  T3 i_mem_req=1, ready after 3 cycles -> state=1 for 3 cycles, all enables 0; on the ready cycle all enables=1; stall_cnt=4.
//  T4 MEM_TIMEOUT=4, i_mem_req=1, ready never -> state=3 and err=1 after 5 edges; i_rst -> state=0, err=0.
//  T5 i_halt=1 in RUN -> mem_wb_en=0, next state=2, all enables 0; i_resume=1 -> state=0 next edge.
//  T6 i_b_taken=1 during MEM_WAIT, ready at cycle 2 -> flush on the ready cycle only; flush_cnt=1.
//   Also: i_rst asserted mid-wait -> outputs reset asynchronously without waiting for a clock edge.

Source files
------------

// File: rtl/pipeline_controller.sv
// Pipeline sequencer: merges hazard stall, branch flush, memory wait and halt into
// per-stage enables, with a small wait/halt/error FSM and saturating perf counters.
module pipeline_controller #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TO_W        = 8,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_stall_req,
  input  logic             i_b_taken,
  input  logic             i_mem_req,
  input  logic             i_mem_ready,
  input  logic             i_halt,
  input  logic             i_resume,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_bubble,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic [1:0]       state,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2,
    ERROR    = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [TO_W-1:0]    wait_q, wait_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic               mem_hit;
  logic               advance;

  assign mem_hit = i_mem_req & ~i_mem_ready;

  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_en    = 1'b0;
    advance      = 1'b0;
    state_d      = state_q;
    wait_d       = wait_q;
    err_d        = err_q;

    unique case (state_q)
      RUN: begin
        advance = ~mem_hit;
        if (i_halt) begin
          state_d = HALT;
        end else if (mem_hit) begin
          state_d = MEM_WAIT;
          wait_d  = TO_W'(1);
        end
      end
      MEM_WAIT: begin
        advance = i_mem_ready;
        if (i_mem_ready) begin
          state_d = RUN;
          wait_d  = '0;
        end else if (wait_q == TO_W'(MEM_TIMEOUT)) begin
          state_d = ERROR;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + TO_W'(1);
        end
      end
      HALT: begin
        if (i_resume) begin
          state_d = RUN;
          wait_d  = '0;
        end
      end
      default: ;
    endcase

    // An advancing cycle applies the stage-2 hazard/branch rules; stall masks the branch.
    if (advance) begin
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
      id_ex_en  = 1'b1;
      if (i_stall_req) begin
        id_ex_bubble = 1'b1;
      end else begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = i_b_taken;
      end
    end

    // Keep the halting instruction parked in WB.
    if (state_q == RUN && i_halt) begin
      mem_wb_en = 1'b0;
    end

    if (i_rst) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_en     = 1'b0;
      id_ex_bubble = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
    end

    stall_cnt_d = stall_cnt_q;
    if ((state_q == RUN || state_q == MEM_WAIT) && !pc_en && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    flush_cnt_d = flush_cnt_q;
    if (if_id_flush && flush_cnt_q != '1) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= RUN;
      wait_q      <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign state     = state_q;
  assign err       = err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
